// File: rtl/ex_forward_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for the 5-stage pipeline.
// Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB destination records and registers the EX mux selects.
module ex_forward_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             inClk,
    input  logic             inReset,
    input  logic [REG_W-1:0] inIdRs,
    input  logic [REG_W-1:0] inIdRt,
    input  logic [REG_W-1:0] inIdDest,
    input  logic             inIdRegWrite,
    input  logic             inIdMemRead,
    input  logic             inIdUsesRt,
    input  logic             inIdAluSrcImm,
    input  logic             inFlush,
    output logic [1:0]       outForwardA,
    output logic [1:0]       outForwardB,
    output logic             outStall,
    output logic             outBubble,
    output logic [CNT_W-1:0] outStallCount
);

    // Select encoding shared with the EX operand muxes.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_IMM   = 2'b11;

    // ID/EX shadow record
    logic [REG_W-1:0] idexRsReg;
    logic [REG_W-1:0] idexRtReg;
    logic [REG_W-1:0] idexDestReg;
    logic             idexRegWriteReg;
    logic             idexMemReadReg;
    logic [1:0]       idexFwdAReg;
    logic [1:0]       idexFwdBReg;

    // EX/MEM and MEM/WB shadow records
    logic [REG_W-1:0] exmemDestReg;
    logic             exmemRegWriteReg;
    logic             exmemMemReadReg;
    logic [REG_W-1:0] memwbDestReg;
    logic             memwbRegWriteReg;

    logic [CNT_W-1:0] stallCountReg;

    logic             loadUse;
    logic             idexHitRs;
    logic             idexHitRt;
    logic [REG_W-1:0] idOperand [2];
    logic [1:0]       fwdNext   [2];
    logic [1:0]       fwdANext;
    logic [1:0]       fwdBNext;

    assign idOperand[0] = inIdRs;
    assign idOperand[1] = inIdRt;

    // A live load in ID/EX whose destination the ID instruction reads must be held one cycle.
    assign idexHitRs = (idexDestReg == inIdRs);
    assign idexHitRt = inIdUsesRt && (idexDestReg == inIdRt);
    assign loadUse   = idexMemReadReg && idexRegWriteReg && (idexDestReg != '0)
                       && (idexHitRs || idexHitRt);

    assign outStall  = loadUse && !inFlush;
    assign outBubble = loadUse || inFlush;

    // The producer now in ID/EX will be in EX/MEM when the consumer reaches EX, so it wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            always_comb begin
                fwdNext[gi] = FWD_REG;
                if (idexRegWriteReg && (idexDestReg != '0)
                        && (idexDestReg == idOperand[gi])) begin
                    fwdNext[gi] = FWD_EXMEM;
                end else if (exmemRegWriteReg && (exmemDestReg != '0)
                        && (exmemDestReg == idOperand[gi])) begin
                    fwdNext[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    assign fwdANext = fwdNext[0];
    assign fwdBNext = inIdAluSrcImm ? FWD_IMM : fwdNext[1];

    always_ff @(posedge inClk) begin
        if (inReset) begin
            idexRsReg        <= '0;
            idexRtReg        <= '0;
            idexDestReg      <= '0;
            idexRegWriteReg  <= 1'b0;
            idexMemReadReg   <= 1'b0;
            idexFwdAReg      <= FWD_REG;
            idexFwdBReg      <= FWD_REG;
            exmemDestReg     <= '0;
            exmemRegWriteReg <= 1'b0;
            exmemMemReadReg  <= 1'b0;
            memwbDestReg     <= '0;
            memwbRegWriteReg <= 1'b0;
        end else begin
            exmemDestReg     <= idexDestReg;
            exmemRegWriteReg <= idexRegWriteReg;
            exmemMemReadReg  <= idexMemReadReg;
            memwbDestReg     <= exmemDestReg;
            memwbRegWriteReg <= exmemRegWriteReg;
            if (outBubble) begin
                idexRsReg       <= '0;
                idexRtReg       <= '0;
                idexDestReg     <= '0;
                idexRegWriteReg <= 1'b0;
                idexMemReadReg  <= 1'b0;
                idexFwdAReg     <= FWD_REG;
                idexFwdBReg     <= FWD_REG;
            end else begin
                idexRsReg       <= inIdRs;
                idexRtReg       <= inIdRt;
                idexDestReg     <= inIdDest;
                idexRegWriteReg <= inIdRegWrite;
                idexMemReadReg  <= inIdMemRead;
                idexFwdAReg     <= fwdANext;
                idexFwdBReg     <= fwdBNext;
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            stallCountReg <= '0;
        end else if (outStall && (stallCountReg != '1)) begin
            stallCountReg <= stallCountReg + CNT_W'(1);
        end
    end

    // MEM/WB and the operand fields of ID/EX mirror the real pipeline but drive no select.
    logic unusedRecords;
    assign unusedRecords = ^{idexRsReg, idexRtReg, exmemMemReadReg, memwbDestReg, memwbRegWriteReg};

    assign outForwardA   = idexFwdAReg;
    assign outForwardB   = idexFwdBReg;
    assign outStallCount = stallCountReg;

endmodule

// File: tb/tb_ex_forward_hazard_ctrl.sv
// Table-driven bench for ex_forward_hazard_ctrl: stall/bubble checked in-cycle, selects and counter via a scoreboard.
module tb_ex_forward_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             inClk;
    logic             inReset;
    logic [REG_W-1:0] inIdRs;
    logic [REG_W-1:0] inIdRt;
    logic [REG_W-1:0] inIdDest;
    logic             inIdRegWrite;
    logic             inIdMemRead;
    logic             inIdUsesRt;
    logic             inIdAluSrcImm;
    logic             inFlush;
    logic [1:0]       outForwardA;
    logic [1:0]       outForwardB;
    logic             outStall;
    logic             outBubble;
    logic [CNT_W-1:0] outStallCount;

    ex_forward_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .inClk         (inClk),
        .inReset       (inReset),
        .inIdRs        (inIdRs),
        .inIdRt        (inIdRt),
        .inIdDest      (inIdDest),
        .inIdRegWrite  (inIdRegWrite),
        .inIdMemRead   (inIdMemRead),
        .inIdUsesRt    (inIdUsesRt),
        .inIdAluSrcImm (inIdAluSrcImm),
        .inFlush       (inFlush),
        .outForwardA   (outForwardA),
        .outForwardB   (outForwardB),
        .outStall      (outStall),
        .outBubble     (outBubble),
        .outStallCount (outStallCount)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    typedef struct {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
        logic             rw;
        logic             mr;
        logic             ur;
        logic             imm;
        logic             fl;
        logic             rst;
        logic             eStall;
        logic             eBubble;
        logic [1:0]       eFa;
        logic [1:0]       eFb;
        logic [CNT_W-1:0] eCnt;
    } vec_t;

    typedef struct {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbQ[$];
    vec_t tbl[24];

    function automatic vec_t mk(input int rs, input int rt, input int dest,
                                input bit rw, input bit mr, input bit ur, input bit imm,
                                input bit fl, input bit rst, input bit st, input bit bu,
                                input logic [1:0] fa, input logic [1:0] fb, input int cnt);
        vec_t v;
        v.rs = REG_W'(rs);  v.rt = REG_W'(rt);  v.dest = REG_W'(dest);
        v.rw = rw;  v.mr = mr;  v.ur = ur;  v.imm = imm;  v.fl = fl;  v.rst = rst;
        v.eStall = st;  v.eBubble = bu;  v.eFa = fa;  v.eFb = fb;  v.eCnt = CNT_W'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        @(negedge inClk);
        inReset       = v.rst;
        inIdRs        = v.rs;
        inIdRt        = v.rt;
        inIdDest      = v.dest;
        inIdRegWrite  = v.rw;
        inIdMemRead   = v.mr;
        inIdUsesRt    = v.ur;
        inIdAluSrcImm = v.imm;
        inFlush       = v.fl;
        #1;
        chk("stall", idx, 16'(outStall), 16'(v.eStall));
        chk("bubble", idx, 16'(outBubble), 16'(v.eBubble));
        e.fa = v.eFa;  e.fb = v.eFb;  e.cnt = v.eCnt;
        sbQ.push_back(e);
        @(posedge inClk);
        #1;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
        end else begin
            e = sbQ.pop_front();
            chk("forwardA", idx, 16'(outForwardA), 16'(e.fa));
            chk("forwardB", idx, 16'(outForwardB), 16'(e.fb));
            chk("stallCount", idx, 16'(outStallCount), 16'(e.cnt));
        end
        $display("step %0d: stall=%b bubble=%b fwdA=%b fwdB=%b count=%0d",
                 idx, outStall, outBubble, outForwardA, outForwardB, outStallCount);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   satCnt;
        vec_t v;

        //           rs rt dst rw mr ur im fl rst  st bu  fA     fB    cnt
        tbl[0]  = mk(1, 2, 3,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0); // add r3,r1,r2
        tbl[1]  = mk(3, 5, 4,  1, 0, 1, 0, 0, 0,   0, 0, 2'b10, 2'b00, 0); // sub r4,r3,r5
        tbl[2]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0); // nop
        tbl[3]  = mk(2, 4, 6,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b01, 0); // or r6,r2,r4
        tbl[4]  = mk(1, 1, 7,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0); // add r7,r1,r1
        tbl[5]  = mk(2, 2, 7,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0); // add r7,r2,r2
        tbl[6]  = mk(7, 7, 8,  1, 0, 1, 0, 0, 0,   0, 0, 2'b10, 2'b10, 0); // and r8,r7,r7: nearer wins
        tbl[7]  = mk(1, 0, 0,  1, 0, 0, 1, 0, 0,   0, 0, 2'b00, 2'b11, 0); // addi r0,r1,7
        tbl[8]  = mk(0, 0, 9,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0); // add r9,r0,r0
        tbl[9]  = mk(1, 1, 3,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0); // add r3,r1,r1
        tbl[10] = mk(3, 5, 5,  1, 0, 0, 1, 0, 0,   0, 0, 2'b10, 2'b11, 0); // addi r5,r3,7
        tbl[11] = mk(1, 2, 2,  1, 1, 0, 1, 0, 0,   0, 0, 2'b00, 2'b11, 0); // lw r2,0(r1)
        tbl[12] = mk(2, 1, 4,  1, 0, 1, 0, 0, 0,   1, 1, 2'b00, 2'b00, 1); // add r4,r2,r1 stalls
        tbl[13] = mk(2, 1, 4,  1, 0, 1, 0, 0, 0,   0, 0, 2'b01, 2'b00, 1); // held add gets WB
        tbl[14] = mk(4, 6, 6,  1, 1, 0, 1, 0, 0,   0, 0, 2'b10, 2'b11, 1); // lw r6,0(r4)
        tbl[15] = mk(6, 7, 7,  1, 1, 0, 1, 0, 0,   1, 1, 2'b00, 2'b00, 2); // lw r7,0(r6) stalls
        tbl[16] = mk(6, 7, 7,  1, 1, 0, 1, 0, 0,   0, 0, 2'b01, 2'b11, 2);
        tbl[17] = mk(1, 7, 8,  1, 0, 1, 0, 0, 0,   1, 1, 2'b00, 2'b00, 3); // add r8,r1,r7 stalls on rt
        tbl[18] = mk(1, 7, 8,  1, 0, 1, 0, 0, 0,   0, 0, 2'b00, 2'b01, 3);
        tbl[19] = mk(1, 2, 2,  1, 1, 0, 1, 0, 0,   0, 0, 2'b00, 2'b11, 3); // lw r2,0(r1)
        tbl[20] = mk(2, 1, 4,  1, 0, 1, 0, 1, 0,   0, 1, 2'b00, 2'b00, 3); // flush beats stall
        tbl[21] = mk(2, 1, 5,  1, 0, 1, 0, 0, 0,   0, 0, 2'b01, 2'b00, 3); // add r5,r2,r1
        tbl[22] = mk(5, 5, 9,  1, 0, 1, 0, 1, 0,   0, 1, 2'b00, 2'b00, 3); // flushed reader of r5
        tbl[23] = mk(5, 0, 10, 1, 0, 1, 0, 0, 0,   0, 0, 2'b01, 2'b00, 3); // add r10,r5,r0

        inReset = 1'b1;  inIdRs = '0;  inIdRt = '0;  inIdDest = '0;
        inIdRegWrite = 1'b0;  inIdMemRead = 1'b0;  inIdUsesRt = 1'b0;
        inIdAluSrcImm = 1'b0;  inFlush = 1'b0;
        repeat (2) @(posedge inClk);
        #1;
        chk("reset forwardA", 0, 16'(outForwardA), 16'd0);
        chk("reset forwardB", 0, 16'(outForwardB), 16'd0);
        chk("reset stallCount", 0, 16'(outStallCount), 16'd0);
        chk("reset stall", 0, 16'(outStall), 16'd0);
        chk("reset bubble", 0, 16'(outBubble), 16'd0);
        $display("reset: fwdA=%b fwdB=%b stall=%b bubble=%b count=%0d",
                 outForwardA, outForwardB, outStall, outBubble, outStallCount);

        for (int i = 0; i < 24; i++) step(tbl[i], i);

        // Reset lands on the stall cycle: state clears, counter does not count that stall.
        step(mk(1, 2, 2, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b11, 3), 100);
        step(mk(2, 1, 4, 1, 0, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0), 101);
        step(mk(2, 1, 4, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 102);

        // Repeated load-use pairs drive the counter into saturation.
        satCnt = 0;
        for (int k = 0; k < 18; k++) begin
            step(mk(1, 2, 2, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b11, satCnt), 200 + 3 * k);
            if (satCnt < (1 << CNT_W) - 1) satCnt++;
            step(mk(2, 1, 4, 1, 0, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, satCnt), 201 + 3 * k);
            step(mk(2, 1, 4, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, satCnt), 202 + 3 * k);
        end
        chk("saturated stallCount", 300, 16'(outStallCount), 16'((1 << CNT_W) - 1));
        chk("scoreboard drained", 301, 16'(sbQ.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
